// File: rtl/serial_word_comparator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_word_comparator_pkg: state encodings and result codes         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package serial_word_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result codes are packed as {lt, eq, gt}.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;

endpackage
`default_nettype wire

// File: rtl/serial_word_comparator_two_bit_comparator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | two_bit_comparator: combinational magnitude compare of 2-bit digits  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module two_bit_comparator (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic       o_lt,
  output logic       o_eq,
  output logic       o_gt
);

  assign o_lt = (i_a <  i_b);
  assign o_eq = (i_a == i_b);
  assign o_gt = (i_a >  i_b);

endmodule
`default_nettype wire

// File: rtl/serial_word_comparator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_word_comparator: MSB-first digit-serial unsigned comparator   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module serial_word_comparator
  import serial_word_comparator_pkg::*;
#(
  parameter  int DIGITS = 4,
  localparam int W      = 2 * DIGITS,
  localparam int CW     = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  a_word,
  input  logic [W-1:0]  b_word,
  output logic          busy,
  output logic          done,
  output logic          result_valid,
  output logic          a_lt_b,
  output logic          a_eq_b,
  output logic          a_gt_b,
  output logic [CW-1:0] digits_used
);

  localparam logic [CW-1:0] c_digits = CW'(DIGITS);

  state_t        r_state;
  logic [W-1:0]  r_sa;
  logic [W-1:0]  r_sb;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_valid;
  logic [2:0]    r_res;
  logic [CW-1:0] r_used;

  logic          w_lt;
  logic          w_eq;
  logic          w_gt;

  two_bit_comparator u_digit (
    .i_a  (r_sa[W-1:W-2]),
    .i_b  (r_sb[W-1:W-2]),
    .o_lt (w_lt),
    .o_eq (w_eq),
    .o_gt (w_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_res   <= RES_NONE;
      r_used  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sa    <= a_word;
            r_sb    <= b_word;
            r_cnt   <= c_digits;
            r_valid <= 1'b0;
            r_res   <= RES_NONE;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!w_eq) begin
            // First unequal digit settles the word-level order.
            r_res   <= {w_lt, 1'b0, w_gt};
            r_used  <= c_digits - r_cnt + CW'(1);
            r_done  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= DONE;
          end else if (r_cnt == CW'(1)) begin
            r_res   <= RES_EQ;
            r_used  <= c_digits;
            r_done  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= DONE;
          end else begin
            r_sa  <= r_sa << 2;
            r_sb  <= r_sb << 2;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_valid;
  assign a_lt_b       = r_res[2];
  assign a_eq_b       = r_res[1];
  assign a_gt_b       = r_res[0];
  assign digits_used  = r_used;

endmodule
`default_nettype wire

// File: doc/serial_word_comparator.md
Name: serial_word_comparator

Overview:
Sequential magnitude comparator for two unsigned words of 2*DIGITS bits. It walks 2-bit digits MSB-first, one digit per clock, and stops at the first unequal digit. Each digit is judged by the team's two_bit_comparator, instantiated once as the per-digit stage. The block consumes that stage's less/equal/greater flags and produces a registered, handshaked word-level result for downstream control logic.

Parameters:
DIGITS, 4, number of 2-bit digits per operand (word width W = 2*DIGITS); legal range 1..16.
CW, derived = clog2(DIGITS+1), width of the digits_used counter.

Ports:
clk  input  1  single system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; accepted only in IDLE.
a_word  input  W  operand A, captured on the accepted start.
b_word  input  W  operand B, captured on the accepted start.
busy  output  1  high in RUN and DONE states.
done  output  1  one-cycle pulse when a result becomes valid.
result_valid  output  1  high from done until the next accepted start.
a_lt_b  output  1  registered result, A < B.
a_eq_b  output  1  registered result, A = B.
a_gt_b  output  1  registered result, A > B.
digits_used  output  CW  number of digits examined for the latest result.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE, all outputs 0, operand shift registers 0, digit counter 0.
- Reset mid-operation aborts immediately. No partial result is kept and no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clock edge → load a_word/b_word into shift registers sa/sb, counter := DIGITS, clear result_valid and result flags, go to RUN.
  - start=0 → stay.
- RUN, every cycle:
  - The current digit is sa[W-1:W-2] vs sb[W-1:W-2], fed through two_bit_comparator.
  - Unequal digit → latch lt/gt accordingly, eq=0, digits_used := DIGITS - counter + 1, go to DONE.
  - Equal and counter==1 → latch eq=1, digits_used := DIGITS, go to DONE.
  - Equal otherwise → shift sa/sb left by 2 (zero fill), counter -= 1, stay in RUN.
- DONE: done=1 and result_valid=1 for exactly this cycle's outputs, then go to IDLE. result_valid and the flags then hold.
- Latency: start sampled in cycle 0. RUN occupies cycles 1..m, where m = digits examined (1..DIGITS). done is high in cycle m+1. Best case 2 cycles, worst case DIGITS+1.
- Result flags are one-hot whenever result_valid=1 and all-zero otherwise.
- start while busy is ignored; operands do not change mid-compare.
- Back-to-back: start may be accepted in the IDLE cycle immediately after DONE.
- a_word/b_word are don't-care except at the accepting edge.
- DIGITS=1: always exactly one RUN cycle.

Decomposition:
- Shared header (included file): state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2; result codes LT/EQ/GT as localparams.
- Sub-module: a single two_bit_comparator instance, combinational, on the top digit of sa/sb.
- No other sub-modules. FSM, counter and shift registers stay in serial_word_comparator.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release → busy=0, done=0, result_valid=0, all flags 0, digits_used=0. Repeat with rst_n dropped during RUN → outputs 0, no done pulse afterwards.
- MSB decides, DIGITS=4: start with A=8'h40, B=8'hC0 → done in cycle 2, a_lt_b=1, digits_used=1.
- Mid-word decision: A=8'hB4, B=8'hB1 → digits 10=10, 11=11, 01>00; done in cycle 4, a_gt_b=1, digits_used=3.
- Equal, worst case: A=B=8'h5A → done in cycle 5, a_eq_b=1, digits_used=4. Also A=B=8'h00 gives the same result.
- LSB decides plus ignored start: A=8'hFE, B=8'hFF; pulse start with A=8'h00 during RUN → that start is ignored; done in cycle 5, a_lt_b=1, digits_used=4; result_valid holds until the next start.
- Back-to-back and random: start the cycle after DONE with A=8'h01, B=8'h00 → a_gt_b=1 after 4 RUN cycles. Then 1000 random pairs at DIGITS=1, 4 and 8 checked against a >, =, < model and a latency model.
